// File: rtl/nes_joypad_poller.sv
// nes_joypad_poller: periodic NES controller reader producing a registered button byte
module nes_joypad_poller #(
    parameter int C_half_cycles   = 128,
    parameter int C_strobe_cycles = 256,
    parameter int C_poll_cycles   = 357955
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic       joy_data,
    output logic       joy_strobe,
    output logic       joy_clock,
    output logic [7:0] buttons,
    output logic       present,
    output logic       valid
);
    localparam int PW  = $clog2(C_poll_cycles);
    localparam int PHW = $clog2(C_strobe_cycles > C_half_cycles ? C_strobe_cycles : C_half_cycles);

    typedef enum logic [2:0] {IDLE, STROBE, BIT0, CLK_HI, CLK_LO, UPDATE} state_t;

    state_t           state;
    logic [1:0]       sync_q;
    logic [PW-1:0]    period;
    logic [PHW-1:0]   phase;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             wrap, half_end, strobe_end, sample;

    assign wrap       = period == PW'(C_poll_cycles - 1);
    assign half_end   = phase == PHW'(C_half_cycles - 1);
    assign strobe_end = phase == PHW'(C_strobe_cycles - 1);
    assign sample     = sync_q[1];

    // two-flop synchronizer; resets to the idle pulled-up level
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], joy_data};

    // free-running poll period counter
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) period <= '0;
        else         period <= wrap ? '0 : period + 1'b1;

    // poll sequencer: strobe, bit 0 window, eight clock pulses, then one update cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            phase      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            joy_strobe <= 1'b0;
            joy_clock  <= 1'b0;
            buttons    <= 8'h00;
            present    <= 1'b0;
            valid      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (wrap && enable) begin
                    state      <= STROBE;
                    joy_strobe <= 1'b1;
                    phase      <= '0;
                end
                STROBE: if (strobe_end) begin
                    state      <= BIT0;
                    joy_strobe <= 1'b0;
                    phase      <= '0;
                end else phase <= phase + 1'b1;
                BIT0: if (half_end) begin
                    shreg     <= {~sample, shreg[7:1]};
                    state     <= CLK_HI;
                    joy_clock <= 1'b1;
                    bit_cnt   <= '0;
                    phase     <= '0;
                end else phase <= phase + 1'b1;
                CLK_HI: if (half_end) begin
                    state     <= CLK_LO;
                    joy_clock <= 1'b0;
                    phase     <= '0;
                end else phase <= phase + 1'b1;
                CLK_LO: if (half_end) begin
                    phase <= '0;
                    if (bit_cnt == 3'd7) begin
                        present <= ~sample;
                        buttons <= sample ? 8'h00 : shreg;
                        valid   <= 1'b1;
                        state   <= UPDATE;
                    end else begin
                        shreg     <= {~sample, shreg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        joy_clock <= 1'b1;
                        state     <= CLK_HI;
                    end
                end else phase <= phase + 1'b1;
                UPDATE: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nes_joypad_poller.sv
// tb_nes_joypad_poller: directed checks of the joypad poller against a behavioural 4021
module tb_nes_joypad_poller;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       joy_data;
    logic       joy_strobe, joy_clock, present, valid;
    logic [7:0] buttons;

    int checks = 0;
    int errors = 0;

    nes_joypad_poller #(.C_half_cycles(4), .C_strobe_cycles(4), .C_poll_cycles(100)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .joy_data(joy_data),
        .joy_strobe(joy_strobe), .joy_clock(joy_clock), .buttons(buttons),
        .present(present), .valid(valid)
    );

    always #5 clock = ~clock;

    // behavioural CD4021 controller; serial input tied low so the 9th read is 0
    logic [7:0] pressed = 8'h00;
    logic       model_on = 1'b0;
    logic [8:0] sreg = 9'h1ff;
    logic       jc_prev = 1'b0;
    assign joy_data = model_on ? sreg[0] : 1'b1;
    always @(posedge clock) begin
        if (joy_strobe) sreg <= {1'b0, ~pressed};
        else if (joy_clock && !jc_prev) sreg <= {1'b0, sreg[8:1]};
        jc_prev <= joy_clock;
    end

    // cycle counter and output monitor
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic strobe_q = 1'b0, clk_q = 1'b0, valid_q = 1'b0;
    int n_rise = 0, n_clk_rise = 0, n_valid = 0, n_bad_clk = 0, n_bad_valid = 0, n_active = 0;
    int s_len = 0, c_len = 0, last_strobe_len = 0, last_rise_cyc = 0, last_valid_cyc = 0;
    always @(negedge clock) begin
        strobe_q <= joy_strobe;
        clk_q    <= joy_clock;
        valid_q  <= valid;
        s_len    <= joy_strobe ? s_len + 1 : 0;
        c_len    <= joy_clock ? c_len + 1 : 0;
        if (joy_strobe && !strobe_q) begin n_rise <= n_rise + 1; last_rise_cyc <= cyc; end
        if (!joy_strobe && strobe_q) last_strobe_len <= s_len;
        if (joy_clock && !clk_q) n_clk_rise <= n_clk_rise + 1;
        if (!joy_clock && clk_q && c_len != 4) n_bad_clk <= n_bad_clk + 1;
        if (valid) begin n_valid <= n_valid + 1; last_valid_cyc <= cyc; end
        if (valid && valid_q) n_bad_valid <= n_bad_valid + 1;
        if (joy_strobe === 1'b1 || joy_clock === 1'b1 || present === 1'b1 || valid === 1'b1 || buttons !== 8'h00)
            n_active <= n_active + 1;
    end

    int rel_cyc = 0;

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            if (valid) ok = 1'b1;
        end
    endtask

    task automatic wait_rise(output bit ok);
        int b;
        b = n_rise;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (n_rise != b) ok = 1'b1;
        end
    endtask

    task automatic wait_pulse(input int base, input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (n_clk_rise - base == k + 1 && joy_clock) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int b_act, b_rise, b_val;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({joy_strobe, joy_clock, buttons, present, valid} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs got %h required 000", {joy_strobe, joy_clock, buttons, present, valid});
        end
        b_act = n_active; b_rise = n_rise; b_val = n_valid;
        resetn = 1'b1;
        rel_cyc = cyc;
        for (int i = 0; i < 200; i++) step();
        checks++;
        if (n_active != b_act) begin errors++; $display("FAIL reset_idle_active got %0d cycles required 0", n_active - b_act); end
        checks++;
        if (n_rise != b_rise) begin errors++; $display("FAIL reset_no_strobe got %0d required 0", n_rise - b_rise); end
        checks++;
        if (n_valid != b_val) begin errors++; $display("FAIL reset_no_valid got %0d required 0", n_valid - b_val); end
    endtask

    task automatic test_nominal();
        int b_rise, b_clk, b_bad;
        bit ok;
        model_on = 1'b1; pressed = 8'hA5;
        b_rise = n_rise; b_clk = n_clk_rise; b_bad = n_bad_clk;
        enable = 1'b1;
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL nominal_valid_timeout got none required pulse"); end
        checks++;
        if (buttons !== 8'hA5) begin errors++; $display("FAIL nominal_buttons got %h required a5", buttons); end
        checks++;
        if (present !== 1'b1) begin errors++; $display("FAIL nominal_present got %b required 1", present); end
        checks++;
        if (n_rise - b_rise != 1) begin errors++; $display("FAIL nominal_strobes got %0d required 1", n_rise - b_rise); end
        checks++;
        if (last_strobe_len != 4) begin errors++; $display("FAIL nominal_strobe_len got %0d required 4", last_strobe_len); end
        checks++;
        if (n_clk_rise - b_clk != 8) begin errors++; $display("FAIL nominal_clk_pulses got %0d required 8", n_clk_rise - b_clk); end
        checks++;
        if (n_bad_clk != b_bad) begin errors++; $display("FAIL nominal_clk_width got %0d bad required 0", n_bad_clk - b_bad); end
        checks++;
        if (last_valid_cyc - last_rise_cyc != 72) begin errors++; $display("FAIL nominal_valid_time got %0d required 72", last_valid_cyc - last_rise_cyc); end
        step();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL nominal_valid_width got %b required 0", valid); end
    endtask

    task automatic test_absent();
        bit ok;
        model_on = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL absent_valid_timeout got none required pulse"); end
        checks++;
        if (buttons !== 8'h00 || present !== 1'b0) begin
            errors++; $display("FAIL absent_result got %h/%b required 00/0", buttons, present);
        end
        step();
        model_on = 1'b1; pressed = 8'h01;
        wait_valid(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reconnect_valid_timeout got none required pulse"); end
        checks++;
        if (buttons !== 8'h01 || present !== 1'b1) begin
            errors++; $display("FAIL reconnect_result got %h/%b required 01/1", buttons, present);
        end
        step();
    endtask

    task automatic test_enable();
        int b_clk, b_rise;
        bit ok;
        pressed = 8'h3C;
        wait_rise(ok);
        b_clk = n_clk_rise;
        wait_pulse(b_clk, 3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL enable_pulse3_timeout got none required pulse"); end
        enable = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok || buttons !== 8'h3C || present !== 1'b1) begin
            errors++; $display("FAIL enable_drop_result got %h/%b required 3c/1", buttons, present);
        end
        b_rise = n_rise;
        for (int i = 0; i < 250; i++) step();
        checks++;
        if (n_rise != b_rise) begin errors++; $display("FAIL enable_off_strobe got %0d required 0", n_rise - b_rise); end
        enable = 1'b1;
        wait_rise(ok);
        checks++;
        if (!ok || (last_rise_cyc - rel_cyc) % 100 != 0) begin
            errors++; $display("FAIL enable_realign got offset %0d required 0", (last_rise_cyc - rel_cyc) % 100);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_pulse(n_clk_rise, 5, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_pulse5_timeout got none required pulse"); end
        checks++;
        if (buttons !== 8'h3C) begin errors++; $display("FAIL mid_pre_buttons got %h required 3c", buttons); end
        resetn = 1'b0;
        #1;
        checks++;
        if (joy_clock !== 1'b0 || buttons !== 8'h00 || present !== 1'b0) begin
            errors++; $display("FAIL mid_reset_async got clk %b btn %h pres %b required 0 00 0", joy_clock, buttons, present);
        end
        pressed = 8'h5A;
        for (int i = 0; i < 3; i++) step();
        resetn = 1'b1;
        rel_cyc = cyc;
        wait_rise(ok);
        checks++;
        if (!ok || last_rise_cyc - rel_cyc != 100) begin
            errors++; $display("FAIL mid_first_strobe got %0d required 100", last_rise_cyc - rel_cyc);
        end
    endtask

    task automatic test_period();
        int prev;
        bit ok;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            checks++;
            if (!ok || last_valid_cyc - last_rise_cyc != 72) begin
                errors++; $display("FAIL period_valid_time poll %0d got %0d required 72", k, last_valid_cyc - last_rise_cyc);
            end
            checks++;
            if (buttons !== 8'h5A) begin errors++; $display("FAIL period_buttons poll %0d got %h required 5a", k, buttons); end
            if (k > 0) begin
                checks++;
                if (last_rise_cyc - prev != 100) begin
                    errors++; $display("FAIL period_spacing poll %0d got %0d required 100", k, last_rise_cyc - prev);
                end
            end
            prev = last_rise_cyc;
            step();
        end
        checks++;
        if (n_bad_valid != 0) begin errors++; $display("FAIL valid_single_cycle got %0d long pulses required 0", n_bad_valid); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_absent();
        test_enable();
        test_reset_mid();
        test_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
